// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl upload (HPS read-back) path.
// Holds the FSM encoding, bus widths and the well-known upload indices.
package ioctl_pkg;

    localparam int         IOCTL_ADDR_W    = 25;
    localparam logic [7:0] IOCTL_FILL_BYTE = 8'hFF;

    localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
    localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } ioctl_state_e;

endpackage

// File: rtl/ioctl_upload_server_if.sv
// Bundle of the hps_io upload signals and the save-RAM read side port.
// slave = the upload server, master = everything around it.
interface ioctl_upload_server_if #(
    parameter int ADDR_W = 10
);
    import ioctl_pkg::*;

    logic                    ioctl_upload;
    logic [7:0]              ioctl_index;
    logic                    ioctl_rd;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;

    logic                    ram_req;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_ack;
    logic [7:0]              ram_data;

    logic                    upload_active;
    logic [ADDR_W:0]         byte_count;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_ack, ram_data,
        output ioctl_din, ioctl_wait, ram_req, ram_addr, upload_active, byte_count
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_ack, ram_data,
        input  ioctl_din, ioctl_wait, ram_req, ram_addr, upload_active, byte_count
    );

endinterface

// File: rtl/ioctl_upload_server.sv
// Answers hps_io upload byte reads from a core-side save RAM via a req/ack port,
// holding the HPS off with ioctl_wait until the byte (or a fill byte) is ready.
module ioctl_upload_server
    import ioctl_pkg::*;
#(
    parameter logic [7:0] UPLOAD_INDEX = IOCTL_IDX_NVRAM,
    parameter int         ADDR_W       = 10,
    parameter int         SIZE         = 1024,
    parameter int         TIMEOUT      = 255
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    ioctl_upload_server_if.slave   bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IOCTL_ADDR_W-1:0] SIZE_L = IOCTL_ADDR_W'(SIZE);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] REQ   = ST_REQ;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        din_q, din_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              act_q, act_dly_q;

    logic strobe, hit, timed_out, busy;
    logic [ADDR_W:0] cnt_inc;

    assign strobe    = bus.ioctl_rd & bus.ioctl_upload & (state_q == IDLE);
    assign hit       = (bus.ioctl_index == UPLOAD_INDEX) && (bus.ioctl_addr < SIZE_L);
    assign timed_out = (timer_q == TW'(TIMEOUT));
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Wait must follow ioctl_upload combinationally so an aborted session releases the HPS at once.
    assign busy           = (state_q != IDLE) & bus.ioctl_upload;
    assign bus.ioctl_wait = busy | strobe;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        din_d   = din_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    if (hit) begin
                        addr_d  = bus.ioctl_addr[ADDR_W-1:0];
                        req_d   = 1'b1;
                        timer_d = '0;
                        state_d = REQ;
                    end else begin
                        din_d = IOCTL_FILL_BYTE;
                    end
                end
            end
            REQ: begin
                timer_d = timer_q + 1'b1;
                if (!bus.ioctl_upload) begin
                    // Session aborted: a response landing this cycle is simply dropped.
                    if (bus.ram_ack || timed_out) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.ram_ack) begin
                    din_d   = bus.ram_data;
                    req_d   = 1'b0;
                    cnt_d   = cnt_inc;
                    state_d = IDLE;
                end else if (timed_out) begin
                    din_d   = IOCTL_FILL_BYTE;
                    req_d   = 1'b0;
                    cnt_d   = cnt_inc;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                timer_d = timer_q + 1'b1;
                if (bus.ram_ack || timed_out) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A new session starts counting from zero; takes priority over any increment.
        if (act_q && !act_dly_q) cnt_d = '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            din_q     <= IOCTL_FILL_BYTE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            act_q     <= 1'b0;
            act_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            din_q     <= din_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            act_q     <= bus.ioctl_upload & (bus.ioctl_index == UPLOAD_INDEX);
            act_dly_q <= act_q;
        end
    end

    assign bus.ioctl_din     = din_q;
    assign bus.ram_req       = req_q;
    assign bus.ram_addr      = addr_q;
    assign bus.upload_active = act_q;
    assign bus.byte_count    = cnt_q;

endmodule
